// File: rtl/keyvalue_wb_initiator_if.sv
// keyvalue_wb_initiator_if: Wishbone-style bus between the initiator and the key/value store slave port
interface keyvalue_wb_initiator_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          STB_o;
    logic          CYC_o;
    logic          WE_o;
    logic          ADR_IS_KEY_o;
    logic          DAT_IS_KEY_o;
    logic [AW-1:0] ADR_o;
    logic [DW-1:0] DAT_o;
    logic          ACK_i;
    logic [DW-1:0] DAT_i;
    logic          DUP_i;
    modport master (
        output STB_o, CYC_o, WE_o, ADR_IS_KEY_o, DAT_IS_KEY_o, ADR_o, DAT_o,
        input  ACK_i, DAT_i, DUP_i
    );
    modport slave (
        input  STB_o, CYC_o, WE_o, ADR_IS_KEY_o, DAT_IS_KEY_o, ADR_o, DAT_o,
        output ACK_i, DAT_i, DUP_i
    );
endinterface

// File: rtl/keyvalue_wb_initiator.sv
// keyvalue_wb_initiator: valid/ready commands to a Wishbone-style key/value slave; KV_INITIATOR_RETRY_EN adds one retry after a timeout
module keyvalue_wb_initiator #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_1,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic                  cmd_adr_is_key,
    input  logic                  cmd_dat_is_key,
    input  logic [AW-1:0]         cmd_adr,
    input  logic [DW-1:0]         cmd_dat,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DW-1:0]         rsp_dat,
    output logic                  rsp_dup,
    output logic                  rsp_timeout,
    keyvalue_wb_initiator_if.master wb,
    output logic                  spurious_ack
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;
`ifdef KV_INITIATOR_RETRY_EN
    localparam logic [1:0] RETRY = 2'd3;
    logic retried;
`endif
    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
    logic [1:0]  state;
    logic [15:0] cnt;
    // strobe is decoded from state so an async reset drops it immediately
    assign wb.STB_o    = state == REQ;
    assign wb.CYC_o    = state == REQ;
    assign cmd_ready   = state == IDLE;
    assign rsp_valid   = state == RESP;
    always_ff @(posedge sys_clk or negedge sys_rst_1) begin
        if (!sys_rst_1) begin
            state           <= IDLE;
            cnt             <= '0;
            wb.WE_o         <= 1'b0;
            wb.ADR_IS_KEY_o <= 1'b0;
            wb.DAT_IS_KEY_o <= 1'b0;
            wb.ADR_o        <= '0;
            wb.DAT_o        <= '0;
            rsp_dat         <= '0;
            rsp_dup         <= 1'b0;
            rsp_timeout     <= 1'b0;
            spurious_ack    <= 1'b0;
`ifdef KV_INITIATOR_RETRY_EN
            retried         <= 1'b0;
`endif
        end else begin
            if (wb.ACK_i && state != REQ) spurious_ack <= 1'b1;
            case (state)
                IDLE: if (cmd_valid) begin
                    wb.WE_o         <= cmd_we;
                    wb.ADR_IS_KEY_o <= cmd_adr_is_key;
                    wb.DAT_IS_KEY_o <= cmd_dat_is_key;
                    wb.ADR_o        <= cmd_adr;
                    wb.DAT_o        <= cmd_dat;
                    cnt             <= '0;
                    state           <= REQ;
`ifdef KV_INITIATOR_RETRY_EN
                    retried         <= 1'b0;
`endif
                end
                REQ: if (wb.ACK_i) begin
                    rsp_dat     <= wb.WE_o ? '0 : wb.DAT_i;
                    rsp_dup     <= wb.DUP_i;
                    rsp_timeout <= 1'b0;
                    state       <= RESP;
                end else if (cnt == LAST) begin
`ifdef KV_INITIATOR_RETRY_EN
                    if (!retried) begin
                        retried <= 1'b1;
                        cnt     <= '0;
                        state   <= RETRY;
                    end else
`endif
                    begin
                        rsp_dat     <= '0;
                        rsp_dup     <= 1'b0;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end
                end else begin
                    cnt <= cnt + 16'd1;
                end
                RESP: if (rsp_ready) begin
                    cnt   <= '0;
                    state <= IDLE;
                end
`ifdef KV_INITIATOR_RETRY_EN
                RETRY: state <= REQ;
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/keyvalue_wb_initiator.md
Name: keyvalue_wb_initiator

Overview:
- Wishbone-style initiator that drives the key/value store's slave port (STB/CYC/WE, ADR/DAT, ADR_IS_KEY/DAT_IS_KEY) from a simple valid/ready command stream.
- Returns read data plus the DUP flag on a valid/ready response stream.
- Sits on the host side (test harness, IO-pin bridge or a future CPU-less controller).
- One transaction outstanding; bounded wait for ACK with a timeout.

Parameters:
- AW, 16, address/key width of ADR_o.
- DW, 16, data width of DAT_o/DAT_i/cmd_dat/rsp_dat.
- TIMEOUT, 255, number of REQ cycles without ACK before the transaction is abandoned (legal range 1..65535).

Ports:
- sys_clk  in  1  clock; all state updates on its rising edge.
- sys_rst_1  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_we  in  1  1=write (put), 0=read (get).
- cmd_adr_is_key  in  1  ADR carries a key.
- cmd_dat_is_key  in  1  DAT carries a key.
- cmd_adr  in  AW  address/key.
- cmd_dat  in  DW  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
- rsp_dat  out  DW  captured DAT_i (reads); 0 for writes and timeouts.
- rsp_dup  out  1  captured DUP_i.
- rsp_timeout  out  1  transaction ended by timeout.
- STB_o  out  1  strobe.
- CYC_o  out  1  cycle.
- WE_o  out  1  write enable.
- ADR_IS_KEY_o  out  1  key qualifier for ADR_o.
- DAT_IS_KEY_o  out  1  key qualifier for DAT_o.
- ADR_o  out  AW  address.
- DAT_o  out  DW  write data.
- ACK_i  in  1  slave acknowledge.
- DAT_i  in  DW  slave read data.
- DUP_i  in  1  slave duplicate-key flag.
- spurious_ack  out  1  sticky flag; set by ACK_i outside REQ.

Behaviour:
- Reset (async assert, sync release): state=IDLE; every output 0 except cmd_ready=1; timeout counter 0.
- States: IDLE, REQ, RESP.
- IDLE:
  - cmd_ready=1; STB_o=CYC_o=0.
  - On handshake, register we, adr_is_key, dat_is_key, adr and dat into the output regs; go to REQ.
  - STB_o/CYC_o rise the cycle after acceptance (1-cycle latency).
- REQ:
  - cmd_ready=0; STB_o=CYC_o=1; all bus outputs held stable.
  - Counter increments each REQ cycle.
  - ACK_i=1 sampled on an edge:
    - capture DAT_i into rsp_dat when WE_o=0, else rsp_dat=0;
    - capture DUP_i into rsp_dup; rsp_timeout=0;
    - STB_o/CYC_o drop on that same edge; rsp_valid=1; go to RESP.
  - Counter reaches TIMEOUT with no ACK: STB_o/CYC_o drop; rsp_valid=1, rsp_timeout=1, rsp_dat=0, rsp_dup=0; go to RESP.
  - ACK wins if it coincides with the timeout cycle.
- RESP:
  - rsp_* held stable while rsp_valid&&!rsp_ready.
  - On handshake: rsp_valid=0; go to IDLE; counter cleared.
  - A new command is not accepted in the same cycle as the response handshake; minimum turnaround is 1 idle cycle.
- ACK_i in IDLE or RESP is ignored for data and sets spurious_ack. Only reset clears spurious_ack.
- WE_o, ADR_o, DAT_o and the key qualifiers retain their last values after a transaction; they are only meaningful while STB_o=1.
- Reset mid-REQ: STB_o/CYC_o drop immediately and asynchronously; any pending response is discarded.

Optional Feature:
- Macro KV_INITIATOR_RETRY_EN.
- Defined:
  - On the first timeout, STB_o/CYC_o deassert for exactly 1 cycle, then the identical request is reissued with a fresh counter.
  - rsp_timeout is raised only if the retry also times out.
  - An added state RETRY sits between REQ and REQ; a 1-bit retried flag is cleared on acceptance.
- Undefined: no retry; behaviour as above.

Test Plan:
- Write: cmd_we=1, adr=0x0012, dat=0xBEEF, adr_is_key=1; slave ACKs on the 3rd REQ cycle with DUP_i=1.
  -> STB_o high for 3 cycles with ADR_o=0x0012, DAT_o=0xBEEF, WE_o=1; rsp_valid with rsp_dat=0, rsp_dup=1, rsp_timeout=0.
- Read: cmd_we=0, adr=0x0012; slave ACKs immediately with DAT_i=0xBEEF.
  -> STB_o high 1 cycle; rsp_dat=0xBEEF, rsp_dup=0.
- Timeout: TIMEOUT=4, no ACK.
  -> STB_o high exactly 4 cycles, then rsp_timeout=1, rsp_dat=0.
  -> With KV_INITIATOR_RETRY_EN: 4 high, 1 low, 4 high, then rsp_timeout=1.
- Backpressure: hold rsp_ready=0 for 10 cycles, cmd_valid=1 continuously.
  -> rsp_* stable, cmd_ready=0, STB_o=0 throughout; after the rsp handshake, cmd_ready=1 one cycle later.
- Spurious/boundary: ACK_i pulse in IDLE -> spurious_ack=1, no rsp_valid. ACK on the TIMEOUT cycle -> rsp_timeout=0 with data captured.
- Reset: assert sys_rst_1=0 mid-REQ -> STB_o=CYC_o=0 and cmd_ready=1 immediately; no response after release.
